// File: rtl/accel_seq_pkg.sv
// rtl/accel_seq_pkg.sv - shared types, constants and command builder for the accelerometer sequencer
// Contents:
//   seq_state_t   top FSM states
//   ERR_*         err_code values
//   register addresses, read / auto-increment masks, init tables
//   spi_cmd_t     {mosi word, nbits} pair
//   cmd_word()    command to present while in a given REQ state
package accel_seq_pkg;

    typedef enum logic [2:0] {
        ST_WHOAMI_REQ,
        ST_WHOAMI_WAIT,
        ST_INIT_REQ,
        ST_INIT_WAIT,
        ST_READ_REQ,
        ST_READ_WAIT,
        ST_PUBLISH,
        ST_HALT
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_WHOAMI  = 2'd1;
    localparam logic [1:0] ERR_INIT    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] WHO_AM_I_ADDR = 8'h0F;
    localparam logic [7:0] OUT_X_L_ADDR  = 8'h28;
    localparam logic [7:0] RD_MASK       = 8'h80;
    localparam logic [7:0] AUTOINC_MASK  = 8'h40;
    localparam logic [7:0] INIT_ACK      = 8'hFF;

    localparam logic [5:0] NBITS_16 = 6'd15;
    localparam logic [5:0] NBITS_24 = 6'd23;

    localparam logic [7:0] INIT_ADDR [4] = '{8'h20, 8'h1F, 8'h23, 8'h24};
    localparam logic [7:0] INIT_DATA [4] = '{8'h77, 8'hC0, 8'h88, 8'h00};

    typedef struct packed {
        logic [31:0] mosi;
        logic [5:0]  nbits;
    } spi_cmd_t;

    // Axis registers are two bytes apart; a 24-bit auto-increment read
    // returns L then H after the command byte.
    function automatic spi_cmd_t cmd_word(input seq_state_t st, input logic [1:0] idx);
        spi_cmd_t c;
        c.mosi  = '0;
        c.nbits = '0;
        case (st)
            ST_WHOAMI_REQ: begin
                c.mosi  = {16'h0, RD_MASK | WHO_AM_I_ADDR, 8'h00};
                c.nbits = NBITS_16;
            end
            ST_INIT_REQ: begin
                c.mosi  = {16'h0, INIT_ADDR[idx], INIT_DATA[idx]};
                c.nbits = NBITS_16;
            end
            ST_READ_REQ: begin
                c.mosi  = {8'h0, RD_MASK | AUTOINC_MASK | (OUT_X_L_ADDR + {5'd0, idx, 1'b0}), 16'h0};
                c.nbits = NBITS_24;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_spi_txn.sv
// rtl/seq_spi_txn.sv - SPI request/wait handshake decode with optional watchdog
// Ports:
//   clk_in, nrst     clock, asynchronous active-low reset
//   start            top FSM is in a REQ state
//   busy             top FSM is in a WAIT state
//   spi_ready        master idle flag
//   spi_miso_data    received word from the master
//   accepted         request taken (spi_ready low while in REQ)
//   done             transfer finished (spi_ready high while in WAIT)
//   rx_word          received word, valid with done
//   timeout          watchdog expired (always 0 unless SEQ_WATCHDOG_EN)
// Optional feature macro: SEQ_WATCHDOG_EN
module seq_spi_txn #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk_in,
    input  logic        nrst,
    input  logic        start,
    input  logic        busy,
    input  logic        spi_ready,
    input  logic [31:0] spi_miso_data,
    output logic        accepted,
    output logic        done,
    output logic [31:0] rx_word,
    output logic        timeout
);

    assign accepted = start & ~spi_ready;
    assign done     = busy & spi_ready;
    assign rx_word  = spi_miso_data;

`ifdef SEQ_WATCHDOG_EN
    logic [15:0] wd_cnt;

    // Every finished transfer leads to a fresh REQ (or out of the handshake),
    // so clearing on done gives a clean count for each transaction.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            wd_cnt <= '0;
        end else if (done || !(start || busy)) begin
            wd_cnt <= '0;
        end else if (!timeout) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    assign timeout = (start || busy) && (wd_cnt == 16'(TIMEOUT_CYC));
`else
    logic unused_wd;
    assign unused_wd = ^{clk_in, nrst, (TIMEOUT_CYC != 0)};
    assign timeout   = 1'b0;
`endif

endmodule

// File: rtl/accel_axis_sequencer.sv
// rtl/accel_axis_sequencer.sv - WHO_AM_I check, register init and multi-axis polling over SPI
// Ports:
//   clk_in, nrst     clock, asynchronous active-low reset
//   spi_mosi_data    command word to the SPI master
//   spi_miso_data    received word, last byte in [7:0]
//   spi_nbits        transfer length minus one
//   spi_request      transaction request
//   spi_ready        master idle
//   led_sel          axis shown on the LED bar (clamped to N_AXES-1)
//   axis_data        latest coherent sweep, axis 0 in LSBs
//   axis_valid       one-cycle pulse per published sweep
//   led_out          active-low one-hot position bar
//   halted, err_code sticky halt flag and cause
// Optional feature macro: SEQ_WATCHDOG_EN (per-transaction timeout)
module accel_axis_sequencer
    import accel_seq_pkg::*;
#(
    parameter int         N_AXES      = 3,
    parameter int         INIT_WORDS  = 3,
    parameter logic [7:0] WHOAMI_VAL  = 8'h33,
    parameter int         LED_W       = 8,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                   clk_in,
    input  logic                   nrst,
    output logic [31:0]            spi_mosi_data,
    input  logic [31:0]            spi_miso_data,
    output logic [5:0]             spi_nbits,
    output logic                   spi_request,
    input  logic                   spi_ready,
    input  logic [1:0]             led_sel,
    output logic [16*N_AXES-1:0]   axis_data,
    output logic                   axis_valid,
    output logic [LED_W-1:0]       led_out,
    output logic                   halted,
    output logic [1:0]             err_code
);

    localparam int LW = $clog2(LED_W);
    localparam int AW = (N_AXES > 1) ? $clog2(N_AXES) : 1;

    seq_state_t              state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [1:0]              err_d;
    logic                    stage_we, publish;
    logic                    in_req, in_wait, req_next;
    logic                    txn_accepted, txn_done, txn_timeout;
    logic [31:0]             rx_word;
    logic [15:0]             rx_sample;
    logic [N_AXES-1:0][15:0] shadow_q;
    logic [AW-1:0]           led_sel_idx;
    logic [LW-1:0]           led_pos;
    spi_cmd_t                cmd_d;
    logic                    unused_rx;

    assign in_req    = state_q inside {ST_WHOAMI_REQ, ST_INIT_REQ, ST_READ_REQ};
    assign in_wait   = state_q inside {ST_WHOAMI_WAIT, ST_INIT_WAIT, ST_READ_WAIT};
    assign req_next  = state_d inside {ST_WHOAMI_REQ, ST_INIT_REQ, ST_READ_REQ};
    assign halted    = (state_q == ST_HALT);
    assign cmd_d     = cmd_word(state_d, idx_d);
    // The read returns L in [15:8] and H in [7:0].
    assign rx_sample = {rx_word[7:0], rx_word[15:8]};
    assign unused_rx = ^rx_word[31:16];

    seq_spi_txn #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_txn (
        .clk_in        (clk_in),
        .nrst          (nrst),
        .start         (in_req),
        .busy          (in_wait),
        .spi_ready     (spi_ready),
        .spi_miso_data (spi_miso_data),
        .accepted      (txn_accepted),
        .done          (txn_done),
        .rx_word       (rx_word),
        .timeout       (txn_timeout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_code;
        stage_we = 1'b0;
        publish  = 1'b0;
        if (txn_timeout) begin
            state_d = ST_HALT;
            err_d   = ERR_TIMEOUT;
        end else begin
            case (state_q)
                ST_WHOAMI_REQ: if (txn_accepted) state_d = ST_WHOAMI_WAIT;
                ST_WHOAMI_WAIT: begin
                    if (txn_done) begin
                        if (rx_word[7:0] != WHOAMI_VAL) begin
                            state_d = ST_HALT;
                            err_d   = ERR_WHOAMI;
                        end else begin
                            state_d = ST_INIT_REQ;
                            idx_d   = 2'd0;
                        end
                    end
                end
                ST_INIT_REQ: if (txn_accepted) state_d = ST_INIT_WAIT;
                ST_INIT_WAIT: begin
                    if (txn_done) begin
                        if (rx_word[7:0] != INIT_ACK) begin
                            state_d = ST_HALT;
                            err_d   = ERR_INIT;
                        end else if (idx_q == 2'(INIT_WORDS - 1)) begin
                            state_d = ST_READ_REQ;
                            idx_d   = 2'd0;
                        end else begin
                            state_d = ST_INIT_REQ;
                            idx_d   = idx_q + 2'd1;
                        end
                    end
                end
                ST_READ_REQ: if (txn_accepted) state_d = ST_READ_WAIT;
                ST_READ_WAIT: begin
                    if (txn_done) begin
                        stage_we = 1'b1;
                        if (idx_q == 2'(N_AXES - 1)) begin
                            state_d = ST_PUBLISH;
                        end else begin
                            state_d = ST_READ_REQ;
                            idx_d   = idx_q + 2'd1;
                        end
                    end
                end
                ST_PUBLISH: begin
                    publish = 1'b1;
                    idx_d   = 2'd0;
                    state_d = ST_READ_REQ;
                end
                ST_HALT: ;
                default: state_d = ST_WHOAMI_REQ;
            endcase
        end
    end

    // LED position comes from the shadow copy, which is exactly what
    // axis_data will hold after the PUBLISH edge.
    always_comb begin
        led_sel_idx = (led_sel >= 2'(N_AXES)) ? AW'(N_AXES - 1) : led_sel[AW-1:0];
        led_pos     = shadow_q[led_sel_idx][15 -: LW];
        led_pos[LW-1] = ~led_pos[LW-1];
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q       <= ST_WHOAMI_REQ;
            idx_q         <= 2'd0;
            err_code      <= ERR_NONE;
            spi_request   <= 1'b0;
            spi_mosi_data <= '0;
            spi_nbits     <= '0;
            shadow_q      <= '0;
            axis_data     <= '0;
            axis_valid    <= 1'b0;
            led_out       <= '1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_code    <= err_d;
            spi_request <= req_next;
            axis_valid  <= publish;
            if (req_next) begin
                spi_mosi_data <= cmd_d.mosi;
                spi_nbits     <= cmd_d.nbits;
            end
            if (stage_we) begin
                shadow_q[idx_q[AW-1:0]] <= rx_sample;
            end
            if (publish) begin
                axis_data <= shadow_q;
                led_out   <= ~(LED_W'(1) << led_pos);
            end
        end
    end

endmodule

// File: tb/tb_accel_axis_sequencer.sv
// tb/tb_accel_axis_sequencer.sv - directed self-checking bench for accel_axis_sequencer
module tb_accel_axis_sequencer;

    localparam int N_AXES = 3;
    localparam int LED_W  = 8;
    localparam int TO_CYC = 64;

    logic        clk_in = 1'b0;
    logic        nrst;
    logic [31:0] spi_mosi_data;
    logic [31:0] spi_miso_data;
    logic [5:0]  spi_nbits;
    logic        spi_request;
    logic        spi_ready;
    logic [1:0]  led_sel;
    logic [47:0] axis_data;
    logic        axis_valid;
    logic [7:0]  led_out;
    logic        halted;
    logic [1:0]  err_code;

    always #5 clk_in = ~clk_in;

    accel_axis_sequencer #(
        .N_AXES(N_AXES), .INIT_WORDS(3), .WHOAMI_VAL(8'h33),
        .LED_W(LED_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_in(clk_in), .nrst(nrst),
        .spi_mosi_data(spi_mosi_data), .spi_miso_data(spi_miso_data),
        .spi_nbits(spi_nbits), .spi_request(spi_request), .spi_ready(spi_ready),
        .led_sel(led_sel), .axis_data(axis_data), .axis_valid(axis_valid),
        .led_out(led_out), .halted(halted), .err_code(err_code)
    );

    // Slave model configuration (written by the main process only)
    logic [7:0]  cfg_whoami;
    logic [7:0]  cfg_init1;
    logic [15:0] cfg_axis [3];
    logic        cfg_stuck;

    // Slave model state (written by the model process only)
    int          lat;
    int          init_cnt;
    int          ai;
    logic [15:0] av;
    logic [31:0] resp;
    logic [31:0] cmd_log [$];

    initial begin
        spi_ready     = 1'b1;
        spi_miso_data = '0;
        lat           = 0;
        init_cnt      = 0;
        resp          = '0;
        forever begin
            @(negedge clk_in);
            if (!nrst) begin
                spi_ready = !cfg_stuck;
                lat       = 0;
                init_cnt  = 0;
                cmd_log.delete();
            end else if (cfg_stuck) begin
                spi_ready = 1'b0;
            end else if (spi_ready && spi_request) begin
                cmd_log.push_back(spi_mosi_data);
                if (spi_nbits == 6'd23) begin
                    ai = (int'(spi_mosi_data[23:16]) - 232) / 2;
                    av = (ai >= 0 && ai < 3) ? cfg_axis[ai] : 16'h0;
                    resp = {16'h0, av[7:0], av[15:8]};
                end else if (spi_mosi_data[15:8] == 8'h8F) begin
                    resp = {24'h0, cfg_whoami};
                end else begin
                    resp = {24'h0, (init_cnt == 1) ? cfg_init1 : 8'hFF};
                    init_cnt++;
                end
                spi_ready = 1'b0;
                lat       = 3;
            end else if (!spi_ready) begin
                lat--;
                if (lat <= 0) begin
                    spi_miso_data = resp;
                    spi_ready     = 1'b1;
                end
            end
        end
    end

    int valid_cnt;
    initial begin
        valid_cnt = 0;
        forever begin
            @(negedge clk_in);
            if (!nrst) valid_cnt = 0;
            else if (axis_valid) valid_cnt++;
        end
    end

    int checks;
    int errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        nrst = 1'b0;
        repeat (2) @(negedge clk_in);
        nrst = 1'b1;
    endtask

    task automatic wait_log(input int n, input string name);
        int k;
        k = 0;
        while (cmd_log.size() < n && k < 2000) begin
            @(negedge clk_in);
            k++;
        end
        chk(name, 64'(k < 2000), 64'd1);
    endtask

    typedef struct {
        logic [7:0]  whoami;
        logic [7:0]  init1;
        logic [15:0] x, y, z;
        logic [1:0]  sel;
        logic        exp_halted;
        logic [1:0]  exp_err;
        logic [7:0]  exp_led;
        logic [47:0] exp_axis;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] w;
        int          n;
        int          req_hi;
        int          reads;

        checks = 0;
        errors = 0;

        vecs[0] = '{8'h33, 8'hFF, 16'h1234, 16'h8000, 16'h7FFF, 2'd1, 1'b0, 2'd0, 8'hFE, 48'h7FFF_8000_1234};
        vecs[1] = '{8'h33, 8'hFF, 16'h1234, 16'h8000, 16'h7FFF, 2'd2, 1'b0, 2'd0, 8'h7F, 48'h7FFF_8000_1234};
        vecs[2] = '{8'h33, 8'hFF, 16'h1234, 16'h8000, 16'h7FFF, 2'd0, 1'b0, 2'd0, 8'hEF, 48'h7FFF_8000_1234};
        vecs[3] = '{8'h33, 8'hFF, 16'h0000, 16'hFFFF, 16'h4000, 2'd3, 1'b0, 2'd0, 8'hBF, 48'h4000_FFFF_0000};
        vecs[4] = '{8'h33, 8'hFF, 16'h0000, 16'hFFFF, 16'h4000, 2'd1, 1'b0, 2'd0, 8'hF7, 48'h4000_FFFF_0000};
        vecs[5] = '{8'h32, 8'hFF, 16'h1234, 16'h8000, 16'h7FFF, 2'd0, 1'b1, 2'd1, 8'hFF, 48'h0};
        vecs[6] = '{8'h33, 8'h00, 16'h1234, 16'h8000, 16'h7FFF, 2'd0, 1'b1, 2'd2, 8'hFF, 48'h0};
        vecs[7] = '{8'h33, 8'hFF, 16'hA000, 16'h0001, 16'hC000, 2'd0, 1'b0, 2'd0, 8'hFD, 48'hC000_0001_A000};
        vecs[8] = '{8'h33, 8'hFF, 16'hA000, 16'h0001, 16'hC000, 2'd2, 1'b0, 2'd0, 8'hFB, 48'hC000_0001_A000};

        nrst        = 1'b0;
        led_sel     = 2'd1;
        cfg_stuck   = 1'b0;
        cfg_whoami  = 8'h33;
        cfg_init1   = 8'hFF;
        cfg_axis[0] = 16'h1234;
        cfg_axis[1] = 16'h8000;
        cfg_axis[2] = 16'h7FFF;

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_request", 64'(spi_request), 64'd0);
        chk("rst_mosi", 64'(spi_mosi_data), 64'd0);
        chk("rst_nbits", 64'(spi_nbits), 64'd0);
        chk("rst_axis", 64'(axis_data), 64'd0);
        chk("rst_valid", 64'(axis_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_err", 64'(err_code), 64'd0);
        chk("rst_led", 64'(led_out), 64'hFF);

        // Command sequence: WHO_AM_I, three init writes, first axis read
        nrst = 1'b1;
        wait_log(5, "cmd_seq_bound");
        w = cmd_log[0]; chk("cmd_whoami", 64'(w), 64'h8F00);
        w = cmd_log[1]; chk("cmd_init0", 64'(w), 64'h2077);
        w = cmd_log[2]; chk("cmd_init1", 64'(w), 64'h1FC0);
        w = cmd_log[3]; chk("cmd_init2", 64'(w), 64'h2388);
        w = cmd_log[4]; chk("cmd_read_x", 64'(w), 64'hE80000);
        chk("read_nbits", 64'(spi_nbits), 64'd23);

        // Reset while in READ_WAIT restarts at WHO_AM_I
        @(negedge clk_in);
        nrst = 1'b0;
        #1;
        chk("rst_in_wait_req", 64'(spi_request), 64'd0);
        repeat (2) @(negedge clk_in);
        nrst = 1'b1;
        wait_log(1, "restart_bound");
        w = cmd_log[0]; chk("restart_cmd", 64'(w), 64'h8F00);

        // Asynchronous drop of a live request
        n = 0;
        while (n < 50) begin
            @(posedge clk_in);
            #2;
            if (spi_request) break;
            n++;
        end
        chk("req_seen_bound", 64'(n < 50), 64'd1);
        nrst = 1'b0;
        #1;
        chk("async_req_drop", 64'(spi_request), 64'd0);
        @(negedge clk_in);

        // Table of complete scenarios
        for (int i = 0; i < 9; i++) begin
            cfg_whoami  = vecs[i].whoami;
            cfg_init1   = vecs[i].init1;
            cfg_axis[0] = vecs[i].x;
            cfg_axis[1] = vecs[i].y;
            cfg_axis[2] = vecs[i].z;
            led_sel     = vecs[i].sel;
            do_reset();
            n = 0;
            while (!(axis_valid || halted) && n < 2000) begin
                @(negedge clk_in);
                n++;
            end
            chk($sformatf("v%0d_bound", i), 64'(n < 2000), 64'd1);
            chk($sformatf("v%0d_halted", i), 64'(halted), 64'(vecs[i].exp_halted));
            chk($sformatf("v%0d_err", i), 64'(err_code), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_axis", i), 64'(axis_data), 64'(vecs[i].exp_axis));
            chk($sformatf("v%0d_led", i), 64'(led_out), 64'(vecs[i].exp_led));
            @(negedge clk_in);
            chk($sformatf("v%0d_valid_cnt", i), 64'(valid_cnt), vecs[i].exp_halted ? 64'd0 : 64'd1);
            if (vecs[i].exp_halted) begin
                req_hi = 0;
                repeat (100) begin
                    @(negedge clk_in);
                    if (spi_request) req_hi++;
                end
                chk($sformatf("v%0d_halt_quiet", i), 64'(req_hi), 64'd0);
                reads = 0;
                for (int j = 0; j < cmd_log.size(); j++) begin
                    w = cmd_log[j];
                    if (w[23:16] != 8'h00) reads++;
                end
                chk($sformatf("v%0d_no_read", i), 64'(reads), 64'd0);
            end
        end

        // spi_ready stuck low
        cfg_stuck = 1'b1;
        do_reset();
`ifdef SEQ_WATCHDOG_EN
        n = 0;
        while (!halted && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk("wd_cycle", 64'(n >= 64 && n <= 66), 64'd1);
        chk("wd_err", 64'(err_code), 64'd3);
`else
        repeat (10000) @(negedge clk_in);
        chk("stuck_halted", 64'(halted), 64'd0);
        chk("stuck_err", 64'(err_code), 64'd0);
        chk("stuck_req", 64'(spi_request), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
